spin_cycle_controller: RTL
==========================

Name: spin_cycle_controller

Overview:
- Sequences the spin phase of a wash programme: door-lock wait, ramp-up to the selected spin speed, timed hold, ramp-down.
- Handles load-imbalance recovery with bounded retries.
- Sits between the programme sequencer (start/abort, selected_spin_speed from the spin-speed LUT) and the motor drive (rpm command).
- Owns spin timing and fault reporting.

Parameters:
- RAMP_STEP, 50, rpm added or removed per tick
- TICK_DIV, 1000, clk cycles per tick (must be >= 2)
- HOLD_TICKS, 60, ticks held at target speed
- REDIST_RPM, 100, laundry-redistribution speed; imbalance is ignored at or below it
- REDIST_TICKS, 8, ticks held at REDIST_RPM before retrying
- MAX_RETRIES, 2, imbalance retries before fault
- LOCK_TIMEOUT, 20, ticks allowed for door_locked

Ports:
- clk, input, 1, clock
- reset, input, 1, asynchronous, active-high
- start, input, 1, level; sampled only in IDLE
- abort, input, 1, level; forces controlled stop
- target_speed, input, 11, selected spin speed in rpm
- door_locked, input, 1, door interlock status
- imbalance, input, 1, load-imbalance sensor, level
- rpm_cmd, output, 11, motor speed command in rpm
- busy, output, 1, high in every state except IDLE and FAULT
- done, output, 1, one-cycle pulse on normal completion
- spin_fault, output, 1, sticky fault flag
- state_o, output, 3, current state encoding for debug

Behaviour:
- Reset values: state IDLE, rpm_cmd 0, busy 0, done 0, spin_fault 0, retry count 0, tick counter 0.
- Tick: the internal counter runs only when state is not IDLE. It pulses tick every TICK_DIV cycles. The counter clears on entry to WAIT_LOCK, so the first tick arrives TICK_DIV cycles after start is accepted.
- All rpm, hold and timeout changes occur only on tick cycles, except the door-loss and abort handling below.

State machine:
- IDLE: on start=1, latch tgt = min(target_speed, 1400), clear retries, go to WAIT_LOCK.
- WAIT_LOCK: go to RAMP_UP the cycle door_locked=1. If LOCK_TIMEOUT ticks pass without it, go to FAULT.
- RAMP_UP: each tick, rpm_cmd = min(rpm_cmd + RAMP_STEP, tgt). The tick on which rpm_cmd equals tgt enters HOLD and loads hold count = HOLD_TICKS. A tgt of 0 enters HOLD on the first tick.
- HOLD: decrement the count on each tick. At 0, go to RAMP_DOWN with the final destination set to 0.
- RAMP_DOWN: each tick, rpm_cmd = rpm_cmd - RAMP_STEP, saturating at the destination (never below 0).
  - Destination 0, reached: go to DONE.
  - Destination REDIST_RPM, reached: go to REDIST and load REDIST_TICKS.
- REDIST: count down REDIST_TICKS, then go back to RAMP_UP.
- DONE: assert done for one cycle, then go to IDLE.
- FAULT: rpm_cmd = 0 and spin_fault = 1. Stays here until reset; start is ignored.

Imbalance:
- Applies in RAMP_UP or HOLD when imbalance=1 and rpm_cmd > REDIST_RPM.
- If retries < MAX_RETRIES: retries++, go to RAMP_DOWN with destination REDIST_RPM.
- Otherwise: go to RAMP_DOWN with destination 0 and set spin_fault on arrival (go to FAULT, not DONE).

Abort and door loss:
- abort=1 in any busy state except DONE: go to RAMP_DOWN with destination 0. On arrival, go to IDLE with no done pulse.
- abort has priority over imbalance. Repeated abort is harmless.
- door_locked=0 in RAMP_UP, HOLD, RAMP_DOWN or REDIST: rpm_cmd forced to 0 in the same clock edge, go to FAULT. This has priority over everything except reset.

Other rules:
- target_speed changes after latching are ignored.
- Reset mid-spin returns rpm_cmd to 0 immediately (asynchronous).
- rpm arithmetic is done 12 bits wide before saturation, so 1400 + RAMP_STEP never wraps.

Decomposition:
- Package spin_pkg:
  - state enum (IDLE, WAIT_LOCK, RAMP_UP, HOLD, RAMP_DOWN, REDIST, DONE, FAULT)
  - MAX_SPIN_RPM = 1400
  - RPM_W = 11
- Sub-module spin_tick_gen: parameter TICK_DIV, inputs clk/reset/enable/clear, output tick.

Test Plan (TICK_DIV=4, RAMP_STEP=50, HOLD_TICKS=3):
- reset, then start, tgt 400, door_locked=1 -> rpm_cmd steps 50..400 over 8 ticks; 3 ticks hold; ramps to 0; one-cycle done; busy low in IDLE.
- target_speed 2000 -> latched tgt 1400; rpm_cmd never exceeds 1400.
- door_locked held 0 for LOCK_TIMEOUT ticks -> FAULT, spin_fault=1; a following start is ignored.
- imbalance pulse at rpm 300 in RAMP_UP -> ramps down to 100, holds REDIST_TICKS, re-ramps. Third imbalance (MAX_RETRIES=2) -> ramps to 0, then FAULT.
- abort in HOLD at 800 -> ramps down to 0; IDLE; done stays 0.
- door_locked drops during HOLD at 800 -> rpm_cmd 0 on the next edge, FAULT; reset mid-ramp -> all outputs 0 at once.

Source files
------------

// File: rtl/spin_pkg.sv
// Shared types and limits for the spin-cycle controller.
package spin_pkg;

    localparam int RPM_W = 11;
    localparam logic [RPM_W-1:0] MAX_SPIN_RPM = 11'd1400;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        RAMP_UP   = 3'd2,
        HOLD      = 3'd3,
        RAMP_DOWN = 3'd4,
        REDIST    = 3'd5,
        DONE      = 3'd6,
        FAULT     = 3'd7
    } state_t;

    function automatic logic [RPM_W-1:0] clamp_rpm(input logic [RPM_W-1:0] v);
        return (v > MAX_SPIN_RPM) ? MAX_SPIN_RPM : v;
    endfunction

endpackage

// File: rtl/spin_tick_gen.sv
// Free-running tick divider: tick pulses once every TICK_DIV enabled cycles.
module spin_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end

    assign tick = enable && !clear && (r_cnt == LAST);

endmodule

// File: rtl/spin_cycle_controller.sv
// Spin-phase sequencer: door-lock wait, ramp up, timed hold, ramp down,
// with bounded imbalance retries, abort handling and a sticky fault state.
module spin_cycle_controller
    import spin_pkg::*;
#(
    parameter int RAMP_STEP    = 50,
    parameter int TICK_DIV     = 1000,
    parameter int HOLD_TICKS   = 60,
    parameter int REDIST_RPM   = 100,
    parameter int REDIST_TICKS = 8,
    parameter int MAX_RETRIES  = 2,
    parameter int LOCK_TIMEOUT = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [RPM_W-1:0] target_speed,
    input  logic             door_locked,
    input  logic             imbalance,
    output logic [RPM_W-1:0] rpm_cmd,
    output logic             busy,
    output logic             done,
    output logic             spin_fault,
    output logic [2:0]       state_o
);

    localparam int CNT_W = 16;
    localparam logic [11:0]      STEP12    = 12'(RAMP_STEP);
    localparam logic [11:0]      REDIST12  = 12'(REDIST_RPM);
    localparam logic [CNT_W-1:0] HOLD_C    = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] REDIST_C  = CNT_W'(REDIST_TICKS);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    state_t           r_state, w_state_nxt;
    logic [RPM_W-1:0] r_rpm, w_rpm_nxt, r_tgt, w_tgt_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_retries, w_retries_nxt;
    logic             r_dest_redist, w_dest_redist_nxt;
    logic             r_aborting, w_aborting_nxt;
    logic             r_fault_pend, w_fault_pend_nxt;

    logic             w_tick, w_clear, w_imb;
    logic [11:0]      w_sum, w_down_dest, w_down;
    logic [RPM_W-1:0] w_up;

    assign w_clear = (r_state == IDLE) && start;

    spin_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (r_state != IDLE),
        .clear  (w_clear),
        .tick   (w_tick)
    );

    // 12-bit arithmetic so the step above the top speed cannot wrap
    assign w_sum       = {1'b0, r_rpm} + STEP12;
    assign w_up        = (w_sum >= {1'b0, r_tgt}) ? r_tgt : w_sum[RPM_W-1:0];
    assign w_down_dest = (r_dest_redist && !abort) ? REDIST12 : 12'd0;
    assign w_down      = ({1'b0, r_rpm} <= w_down_dest + STEP12) ? w_down_dest
                                                                 : {1'b0, r_rpm} - STEP12;
    assign w_imb       = imbalance && ({1'b0, r_rpm} > REDIST12);

    always_comb begin
        w_state_nxt       = r_state;
        w_rpm_nxt         = r_rpm;
        w_tgt_nxt         = r_tgt;
        w_cnt_nxt         = r_cnt;
        w_retries_nxt     = r_retries;
        w_dest_redist_nxt = r_dest_redist;
        w_aborting_nxt    = r_aborting;
        w_fault_pend_nxt  = r_fault_pend;

        case (r_state)
            IDLE: if (start) begin
                w_state_nxt       = WAIT_LOCK;
                w_tgt_nxt         = clamp_rpm(target_speed);
                w_retries_nxt     = '0;
                w_cnt_nxt         = '0;
                w_dest_redist_nxt = 1'b0;
                w_aborting_nxt    = 1'b0;
                w_fault_pend_nxt  = 1'b0;
            end
            WAIT_LOCK: begin
                if (door_locked)
                    w_state_nxt = RAMP_UP;
                else if (w_tick) begin
                    if (r_cnt >= LOCK_LAST) w_state_nxt = FAULT;
                    else                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            RAMP_UP: if (w_tick) begin
                w_rpm_nxt = w_up;
                if (w_up == r_tgt) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = HOLD_C;
                end
            end
            HOLD: if (w_tick) begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt       = RAMP_DOWN;
                    w_dest_redist_nxt = 1'b0;
                end else
                    w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            RAMP_DOWN: if (w_tick) begin
                w_rpm_nxt = w_down[RPM_W-1:0];
                if (w_down == w_down_dest) begin
                    if (r_dest_redist && !abort) begin
                        w_state_nxt = REDIST;
                        w_cnt_nxt   = REDIST_C;
                    end else if (r_fault_pend)
                        w_state_nxt = FAULT;
                    else if (r_aborting || abort)
                        w_state_nxt = IDLE;
                    else
                        w_state_nxt = DONE;
                end
            end
            REDIST: if (w_tick) begin
                if (r_cnt <= CNT_W'(1)) w_state_nxt = RAMP_UP;
                else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
            end
            DONE:    w_state_nxt = IDLE;
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = IDLE;
        endcase

        // Overrides in rising priority: imbalance, abort, door loss
        if (w_imb && (r_state inside {RAMP_UP, HOLD})) begin
            w_state_nxt = RAMP_DOWN;
            w_rpm_nxt   = r_rpm;
            if (r_retries < RETRY_MAX) begin
                w_retries_nxt     = r_retries + 4'd1;
                w_dest_redist_nxt = 1'b1;
            end else begin
                w_dest_redist_nxt = 1'b0;
                w_fault_pend_nxt  = 1'b1;
            end
        end

        if (abort && (r_state inside {WAIT_LOCK, RAMP_UP, HOLD, RAMP_DOWN, REDIST})) begin
            w_aborting_nxt    = 1'b1;
            w_dest_redist_nxt = 1'b0;
            if (r_state != RAMP_DOWN) begin
                w_state_nxt      = RAMP_DOWN;
                w_rpm_nxt        = r_rpm;
                w_retries_nxt    = r_retries;
                w_fault_pend_nxt = r_fault_pend;
            end
        end

        if (!door_locked && (r_state inside {RAMP_UP, HOLD, RAMP_DOWN, REDIST}))
            w_state_nxt = FAULT;

        if (w_state_nxt == FAULT)
            w_rpm_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rpm         <= '0;
            r_tgt         <= '0;
            r_cnt         <= '0;
            r_retries     <= '0;
            r_dest_redist <= 1'b0;
            r_aborting    <= 1'b0;
            r_fault_pend  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rpm         <= w_rpm_nxt;
            r_tgt         <= w_tgt_nxt;
            r_cnt         <= w_cnt_nxt;
            r_retries     <= w_retries_nxt;
            r_dest_redist <= w_dest_redist_nxt;
            r_aborting    <= w_aborting_nxt;
            r_fault_pend  <= w_fault_pend_nxt;
        end
    end

    assign rpm_cmd    = r_rpm;
    assign busy       = (r_state != IDLE) && (r_state != FAULT);
    assign done       = (r_state == DONE);
    assign spin_fault = (r_state == FAULT);
    assign state_o    = r_state;

endmodule
